popcount_window_accumulator: RTL and testbench

//  Consumes the per-cycle popcount from a 1-bit adder tree (e.g. 64 inputs -> 7-bit sum).

---
 rtl/popcount_pkg.sv | 24 ++
 rtl/stoch_scaled_bit.sv | 57 +++++
 rtl/popcount_window_accumulator.sv | 104 ++++++++++
 tb/tb_popcount_window_accumulator.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/popcount_pkg.sv
// Shared definitions for the popcount accumulator family.
// Holds the default configuration, the width-derivation functions used by every
// module parameter list, and the default popcount sample type.
package popcount_pkg;

    localparam int unsigned DEFAULT_N_IN   = 64;
    localparam int unsigned DEFAULT_WINDOW = 256;

    // Width of a popcount of n_in bits: must hold the value n_in itself.
    function automatic int unsigned sum_w_of(input int unsigned n_in);
        return $clog2(n_in) + 1;
    endfunction

    // Width of a windowed total: window * n_in fits without overflow.
    function automatic int unsigned acc_w_of(input int unsigned n_in, input int unsigned window);
        return sum_w_of(n_in) + $clog2(window);
    endfunction

    localparam int unsigned DEFAULT_SUM_W = sum_w_of(DEFAULT_N_IN);
    localparam int unsigned DEFAULT_ACC_W = acc_w_of(DEFAULT_N_IN, DEFAULT_WINDOW);

    typedef logic [DEFAULT_SUM_W-1:0] sum_t;

endpackage

// File: rtl/stoch_scaled_bit.sv
// Error-feedback stochastic scaler: emits one bit per enabled sample so that the
// long-run density of ones equals s / N_IN.
// Ports:
//   CLK, nRST   clock (rising edge), asynchronous active-low reset
//   en          sample s is accepted this cycle
//   clr         synchronous clear of the error state (wins over en)
//   s           sample, must already be limited to [0, N_IN]
//   bit_out     scaled bit for the last accepted sample (held between samples)
//   bit_valid   one-cycle pulse after each accepted sample
module stoch_scaled_bit
    import popcount_pkg::*;
#(
    parameter int unsigned N_IN  = DEFAULT_N_IN,
    parameter int unsigned SUM_W = sum_w_of(N_IN)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             en,
    input  logic             clr,
    input  logic [SUM_W-1:0] s,
    output logic             bit_out,
    output logic             bit_valid
);

    localparam logic [SUM_W:0] NFull = (SUM_W + 1)'(N_IN);

    // err stays below N_IN, so err + s < 2*N_IN; one extra bit keeps t exact.
    logic [SUM_W-1:0] err;
    logic [SUM_W:0]   t;
    logic [SUM_W:0]   t_wrap;

    assign t      = {1'b0, err} + {1'b0, s};
    assign t_wrap = t - NFull;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            err       <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
        end else if (clr) begin
            err       <= '0;
            bit_valid <= 1'b0;
        end else if (en) begin
            bit_valid <= 1'b1;
            if (t >= NFull) begin
                bit_out <= 1'b1;
                err     <= t_wrap[SUM_W-1:0];
            end else begin
                bit_out <= 1'b0;
                err     <= t[SUM_W-1:0];
            end
        end else begin
            bit_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/popcount_window_accumulator.sv
// Popcount window accumulator: sums WINDOW accepted popcounts into a total offered
// on a valid/ready port, and drives a stochastic bitstream at rate sum/N_IN.
// Ports:
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready   input handshake for sum
//   sum                  popcount from the upstream adder tree
//   clear                sync: drop partial window, error state and range_err
//   out_valid, out_ready output handshake for total
//   total                sum of the last completed window
//   bit_out, bit_valid   scaled stochastic bit and its per-sample strobe
//   range_err            sticky: an accepted sum exceeded N_IN
module popcount_window_accumulator
    import popcount_pkg::*;
#(
    parameter int unsigned  N_IN   = DEFAULT_N_IN,
    parameter int unsigned  WINDOW = DEFAULT_WINDOW,
    localparam int unsigned SUM_W  = sum_w_of(N_IN),
    localparam int unsigned ACC_W  = acc_w_of(N_IN, WINDOW)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUM_W-1:0] sum,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] total,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             range_err
);

    localparam int unsigned      CNT_W   = $clog2(WINDOW);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(WINDOW - 1);
    localparam logic [SUM_W-1:0] SumMax  = SUM_W'(N_IN);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0] cnt;
    logic [SUM_W-1:0] s;
    logic             over;
    logic             cnt_last;
    logic             accept;

    assign over     = sum > SumMax;
    assign s        = over ? SumMax : sum;
    assign cnt_last = cnt == CntLast;
    assign acc_next = acc + ACC_W'(s);

    // Stall only the sample that would complete a window while the previous
    // total is still unclaimed; earlier samples can still be absorbed into acc.
    assign in_ready = ~(out_valid & ~out_ready & cnt_last);
    assign accept   = in_valid & in_ready & ~clear;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            acc       <= '0;
            cnt       <= '0;
            range_err <= 1'b0;
            total     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (clear) begin
                acc       <= '0;
                cnt       <= '0;
                range_err <= 1'b0;
            end else if (accept) begin
                if (over) begin
                    range_err <= 1'b1;
                end
                if (cnt_last) begin
                    acc <= '0;
                    cnt <= '0;
                end else begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                end
            end

            // A completing window overrides a same-cycle drain of the old total.
            if (accept && cnt_last) begin
                total     <= acc_next;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    stoch_scaled_bit #(
        .N_IN  (N_IN),
        .SUM_W (SUM_W)
    ) u_scaled_bit (
        .CLK       (CLK),
        .nRST      (nRST),
        .en        (accept),
        .clr       (clear),
        .s         (s),
        .bit_out   (bit_out),
        .bit_valid (bit_valid)
    );

endmodule

// File: tb/tb_popcount_window_accumulator.sv
module tb_popcount_window_accumulator;
    import popcount_pkg::*;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       in_valid;
    logic       in_ready;
    sum_t       sum;
    logic       clear;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] total;
    logic       bit_out;
    logic       bit_valid;
    logic       range_err;

    int n_tests = 0;
    int n_fail  = 0;

    popcount_window_accumulator #(
        .N_IN   (64),
        .WINDOW (4)
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .total     (total),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .range_err (range_err)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input int v);
        in_valid = 1'b1;
        sum      = 7'(v);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'($urandom);
            sum       = 7'($urandom);
            clear     = 1'($urandom);
            out_ready = 1'($urandom);
            tick();
            n_tests++;
            if ({out_valid, total, bit_out, bit_valid, range_err} !== 13'd0) begin
                n_fail++;
                $display("FAIL reset_outputs: got ov=%b total=%0d bit=%b bv=%b re=%b, want all 0",
                         out_valid, total, bit_out, bit_valid, range_err);
            end
        end
        in_valid  = 1'b0;
        sum       = '0;
        clear     = 1'b0;
        out_ready = 1'b1;
        nRST      = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [3:0] exp_bits;
        exp_bits = 4'b1010;  // index 0 first: 0,1,0,1
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(32);
            n_tests++;
            if (bit_out !== exp_bits[i] || bit_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_bit[%0d]: got bit=%b bv=%b, want bit=%b bv=1",
                         i, bit_out, bit_valid, exp_bits[i]);
            end
            if (i < 3) begin
                n_tests++;
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL basic_early_valid[%0d]: got %b want 0", i, out_valid);
                end
            end
        end
        n_tests++;
        if (out_valid !== 1'b1 || total !== 9'd128) begin
            n_fail++;
            $display("FAIL basic_total: got ov=%b total=%0d, want ov=1 total=128",
                     out_valid, total);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || bit_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_drain: got ov=%b bv=%b, want 0 0", out_valid, bit_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(10);
        for (int i = 0; i < 3; i++) send(20);
        n_tests++;
        if (out_valid !== 1'b1 || total !== 9'd40) begin
            n_fail++;
            $display("FAIL bp_window_a: got ov=%b total=%0d, want ov=1 total=40", out_valid, total);
        end
        in_valid = 1'b1;
        sum      = 7'd5;
        #1;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_in_ready_low: got %b want 0", in_ready);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || total !== 9'd40 || bit_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold: got ov=%b total=%0d bv=%b, want ov=1 total=40 bv=0",
                     out_valid, total, bit_valid);
        end
        out_ready = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_in_ready_high: got %b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || total !== 9'd65 || bit_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_window_b: got ov=%b total=%0d bv=%b, want ov=1 total=65 bv=1",
                     out_valid, total, bit_valid);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: got ov=%b want 0", out_valid);
        end
    endtask

    task automatic test_range();
        out_ready = 1'b1;
        send(100);
        n_tests++;
        if (range_err !== 1'b1 || bit_out !== 1'b1) begin
            n_fail++;
            $display("FAIL range_flag: got re=%b bit=%b, want re=1 bit=1", range_err, bit_out);
        end
        for (int i = 0; i < 3; i++) send(0);
        n_tests++;
        if (out_valid !== 1'b1 || total !== 9'd64 || range_err !== 1'b1) begin
            n_fail++;
            $display("FAIL range_clamp: got ov=%b total=%0d re=%b, want ov=1 total=64 re=1",
                     out_valid, total, range_err);
        end
        tick();
    endtask

    task automatic test_clear();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(10);
        send(64);
        send(64);
        in_valid = 1'b1;
        sum      = 7'd64;
        clear    = 1'b1;
        tick();
        in_valid = 1'b0;
        clear    = 1'b0;
        n_tests++;
        if (bit_valid !== 1'b0 || range_err !== 1'b0 || out_valid !== 1'b1 || total !== 9'd40) begin
            n_fail++;
            $display("FAIL clear_state: got bv=%b re=%b ov=%b total=%0d, want bv=0 re=0 ov=1 total=40",
                     bit_valid, range_err, out_valid, total);
        end
        out_ready = 1'b1;
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_drain: got ov=%b want 0", out_valid);
        end
        for (int i = 0; i < 4; i++) send(1);
        n_tests++;
        if (out_valid !== 1'b1 || total !== 9'd4) begin
            n_fail++;
            $display("FAIL clear_window: got ov=%b total=%0d, want ov=1 total=4", out_valid, total);
        end
        // err was cleared, so 4 + 59 stays below 64.
        send(59);
        n_tests++;
        if (bit_out !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_err: got bit=%b want 0", bit_out);
        end
        for (int i = 0; i < 3; i++) send(0);
        n_tests++;
        if (out_valid !== 1'b1 || total !== 9'd59) begin
            n_fail++;
            $display("FAIL clear_next_window: got ov=%b total=%0d, want ov=1 total=59",
                     out_valid, total);
        end
        tick();
    endtask

    task automatic test_gaps();
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) begin
                n_tests++;
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL gaps_early: got ov=%b want 0", out_valid);
                end
            end
            send(i);
            if (i < 4) tick();
        end
        n_tests++;
        if (out_valid !== 1'b1 || total !== 9'd10) begin
            n_fail++;
            $display("FAIL gaps_total: got ov=%b total=%0d, want ov=1 total=10", out_valid, total);
        end
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(5);
        for (int i = 0; i < 3; i++) send(7);
        n_tests++;
        if (out_valid !== 1'b1 || total !== 9'd20) begin
            n_fail++;
            $display("FAIL simul_a: got ov=%b total=%0d, want ov=1 total=20", out_valid, total);
        end
        out_ready = 1'b1;
        send(9);
        n_tests++;
        if (out_valid !== 1'b1 || total !== 9'd30) begin
            n_fail++;
            $display("FAIL simul_b: got ov=%b total=%0d, want ov=1 total=30", out_valid, total);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_drain: got ov=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(10);
        nRST = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || total !== 9'd0 || bit_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got ov=%b total=%0d bit=%b, want 0 0 0",
                     out_valid, total, bit_out);
        end
        tick();
        nRST = 1'b1;
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(1);
        n_tests++;
        if (out_valid !== 1'b1 || total !== 9'd4) begin
            n_fail++;
            $display("FAIL reset_mid_window: got ov=%b total=%0d, want ov=1 total=4",
                     out_valid, total);
        end
    endtask

    task automatic test_rate();
        int sum_all;
        int win_sum;
        int ones;
        int v;
        sum_all = 0;
        win_sum = 0;
        ones    = 0;
        clear   = 1'b1;
        tick();
        clear     = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 1024; k++) begin
            v = int'($urandom_range(64, 0));
            sum_all += v;
            win_sum += v;
            send(v);
            if (bit_valid === 1'b1 && bit_out === 1'b1) ones++;
            if (k % 4 == 3) begin
                n_tests++;
                if (out_valid !== 1'b1 || total !== 9'(win_sum)) begin
                    n_fail++;
                    $display("FAIL rate_window[%0d]: got ov=%b total=%0d, want ov=1 total=%0d",
                             k / 4, out_valid, total, win_sum);
                end
                win_sum = 0;
            end
        end
        n_tests++;
        if (ones != sum_all / 64) begin
            n_fail++;
            $display("FAIL rate_ones: got %0d want %0d (sum %0d)", ones, sum_all / 64, sum_all);
        end
    endtask

    initial begin
        in_valid  = 1'b0;
        sum       = '0;
        clear     = 1'b0;
        out_ready = 1'b0;
        nRST      = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_range();
        test_clear();
        test_gaps();
        test_reset_mid();
        test_rate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
